mem_port_arbiter: RTL

//  Shares the single memory interface (en/W_R/wordsize/sign, busy/done handshake) between two

---
 rtl/mem_port_arbiter_if.sv | 18 +
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester-side port of the memory arbiter: one-cycle command pulse in,
// busy level plus done/err pulses back.
interface mem_port_arbiter_if;
   logic        en;
   logic [1:0]  W_R;
   logic [1:0]  wordsize;
   logic        sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;

   modport master (output en, W_R, wordsize, sign, addr, wdata,
                   input  busy, done, err);
   modport slave  (input  en, W_R, wordsize, sign, addr, wdata,
                   output busy, done, err);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single memory interface, one
// transaction in flight at a time, with a watchdog that aborts hung accesses.
module mem_port_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave r0,
   mem_port_arbiter_if.slave r1,
   output logic [31:0]       rdata,
   output logic              en_mem,
   output logic [1:0]        W_R_mem,
   output logic [1:0]        wordsize_mem,
   output logic              sign_mem,
   output logic [31:0]       addr_mem,
   output logic [31:0]       wdata_mem,
   input  logic              busy_mem,
   input  logic              done_mem,
   input  logic [31:0]       rdata_mem,
   output logic              timeout_err
);

   typedef struct packed {
      logic [1:0]  w_r;
      logic [1:0]  wordsize;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t          state, state_d;
   logic            grant, grant_d, last_grant;
   logic [1:0]      pend, req_en, done_q, err_q;
   logic            tmo_q;
   cmd_t [1:0]      req_cmd, cmd_q;
   cmd_t            mem_cmd;
   logic [TW-1:0]   wd_cnt;
   logic            wd_expired, fin;

   assign req_en     = {r1.en, r0.en};
   assign req_cmd[0] = {r0.W_R, r0.wordsize, r0.sign, r0.addr, r0.wdata};
   assign req_cmd[1] = {r1.W_R, r1.wordsize, r1.sign, r1.addr, r1.wdata};

   // A completion in the same cycle as the watchdog limit counts as success.
   assign wd_expired = (state == WAIT) && !done_mem && (wd_cnt == TW'(TIMEOUT - 1));
   assign fin        = (state == WAIT) && (done_mem || wd_expired);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grant <= 1'b0;
      end else begin
         state <= state_d;
         grant <= grant_d;
      end
   end

   always_comb begin
      state_d = state;
      grant_d = grant;
      case (state)
         IDLE: begin
            if (!busy_mem && (pend != 2'b00)) begin
               state_d = ISSUE;
               if (pend == 2'b11) grant_d = ~last_grant;
               else               grant_d = pend[1];
            end
         end
         ISSUE:   state_d = WAIT;
         WAIT:    if (fin) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend       <= 2'b00;
         cmd_q      <= '0;
         last_grant <= 1'b1;
         done_q     <= 2'b00;
         err_q      <= 2'b00;
         tmo_q      <= 1'b0;
         rdata      <= '0;
         wd_cnt     <= '0;
      end else begin
         done_q <= 2'b00;
         err_q  <= 2'b00;
         tmo_q  <= 1'b0;
         wd_cnt <= (state == WAIT) ? wd_cnt + TW'(1) : '0;
         // Requests arriving while a port is busy are dropped on the floor.
         for (int p = 0; p < 2; p++) begin
            if (req_en[p] && !pend[p]) begin
               cmd_q[p] <= req_cmd[p];
               pend[p]  <= 1'b1;
            end
         end
         if (fin) begin
            pend[grant]   <= 1'b0;
            done_q[grant] <= 1'b1;
            last_grant    <= grant;
            if (done_mem) begin
               rdata <= rdata_mem;
            end else begin
               err_q[grant] <= 1'b1;
               tmo_q        <= 1'b1;
            end
         end
      end
   end

   assign mem_cmd      = (state != IDLE) ? cmd_q[grant] : '0;
   assign en_mem       = (state == ISSUE);
   assign W_R_mem      = mem_cmd.w_r;
   assign wordsize_mem = mem_cmd.wordsize;
   assign sign_mem     = mem_cmd.sign;
   assign addr_mem     = mem_cmd.addr;
   assign wdata_mem    = mem_cmd.wdata;
   assign timeout_err  = tmo_q;

   assign r0.busy = pend[0];
   assign r0.done = done_q[0];
   assign r0.err  = err_q[0];
   assign r1.busy = pend[1];
   assign r1.done = done_q[1];
   assign r1.err  = err_q[1];

endmodule
